// File: rtl/io_bus_responder.sv
// Memory-mapped I/O slave at word window 0x3Fxx: LED, synchronised switches, 8-digit 7-seg scanner.
// Define IO_TIMER_EN to build the 32-bit timer (TCNT/TCMP/TCTRL at 0x3F04-0x3F06).
module io_bus_responder #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [13:0] adr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_o
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [23:0]   led_q, led_d;
  logic [23:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [31:0]   disp_q, disp_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_en_q, seg_en_d, seg_q, seg_d;
  logic          wr;

  assign hit_o    = (adr_i[13:8] == 6'h3F);
  assign wr       = we_i & hit_o;
  assign led_o    = led_q;
  assign seg_en_o = seg_en_q;
  assign seg_o    = seg_q;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
    led_d      = led_q;
    disp_d     = disp_q;
    sw_s1_d    = sw_i;
    sw_s2_d    = sw_s1_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    // Display outputs are registered from the current index/DISP, hence one cycle of lag.
    seg_en_d = ~(8'b1 << idx_q);
    seg_d    = hex_seg(disp_q[{idx_q, 2'b00} +: 4]);
    if (wr && adr_i[7:0] == 8'h00) led_d  = wdata_i[23:0];
    if (wr && adr_i[7:0] == 8'h02) disp_d = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      disp_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_en_q   <= 8'hFF;
      seg_q      <= 8'hFF;
    end else begin
      led_q      <= led_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      disp_q     <= disp_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_en_q   <= seg_en_d;
      seg_q      <= seg_d;
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic        en_q, en_d, match_q, match_d, autoclr_q, autoclr_d;
  logic        cmp_hit;

  always_comb begin
    tcnt_d    = tcnt_q;
    tcmp_d    = tcmp_q;
    en_d      = en_q;
    match_d   = match_q;
    autoclr_d = autoclr_q;
    cmp_hit   = en_q && (tcnt_q == tcmp_q);
    if (en_q) tcnt_d = (cmp_hit && autoclr_q) ? 32'd0 : tcnt_q + 32'd1;
    // Setting MATCH takes priority over a simultaneous W1C clear.
    if (cmp_hit) match_d = 1'b1;
    else if (wr && adr_i[7:0] == 8'h06 && wdata_i[1]) match_d = 1'b0;
    if (wr && adr_i[7:0] == 8'h04) tcnt_d = wdata_i;
    if (wr && adr_i[7:0] == 8'h05) tcmp_d = wdata_i;
    if (wr && adr_i[7:0] == 8'h06) begin
      en_d      = wdata_i[0];
      autoclr_d = wdata_i[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tcnt_q    <= '0;
      tcmp_q    <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      match_q   <= 1'b0;
      autoclr_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      tcmp_q    <= tcmp_d;
      en_q      <= en_d;
      match_q   <= match_d;
      autoclr_q <= autoclr_d;
    end
  end
`endif

  always_comb begin
    rdata_o = '0;
    if (hit_o) begin
      case (adr_i[7:0])
        8'h00:   rdata_o = {8'h0, led_q};
        8'h01:   rdata_o = {8'h0, sw_s2_q};
        8'h02:   rdata_o = disp_q;
`ifdef IO_TIMER_EN
        8'h04:   rdata_o = tcnt_q;
        8'h05:   rdata_o = tcmp_q;
        8'h06:   rdata_o = {29'h0, autoclr_q, match_q, en_q};
`endif
        default: rdata_o = '0;
      endcase
    end
  end
endmodule
